seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the datapath's combinational 32-bit ALU. Single-cycle ops (add/sub/logic/shift/rotate/neg/not) complete in one clock. Signed multiply (radix-2 Booth) and signed divide (non-restoring) iterate over WIDTH clocks behind a start/busy/done handshake. Results land in registered Zhigh/Zlow for the Z register pair in the CPU datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/muldiv_core.sv | 105 ++++++++++
 rtl/seq_alu.sv | 114 +++++++++++
 tb/tb_seq_alu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and elaboration helpers for the
// sequential ALU and its iterative multiply/divide datapath.
package alu_pkg;

  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_SHR  = 7;
  localparam int OP_SHRA = 8;
  localparam int OP_SHL  = 9;
  localparam int OP_ROR  = 10;
  localparam int OP_ROL  = 11;
  localparam int OP_NEG  = 12;
  localparam int OP_NOT  = 13;
  localparam int OP_MUL  = 14;
  localparam int OP_DIV  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (non-restoring on
// magnitudes) sharing one accumulator, one shift register and one step counter.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = clog2(WIDTH);

  // One guard bit on the accumulator absorbs the -(most negative) overflow in
  // Booth and the 2R+1 growth in the divider.
  logic [WIDTH:0]     acc, m;
  logic [WIDTH-1:0]   q;
  logic               q_m1;
  logic               div_r, neg_q, neg_r;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     sum, shifted, trial, acc_n;
  logic [WIDTH-1:0]   q_n, rem;
  logic               qm1_n;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    sum     = '0;
    shifted = '0;
    trial   = '0;
    acc_n   = acc;
    q_n     = q;
    qm1_n   = q_m1;
    rem     = '0;
    res_hi  = '0;
    res_lo  = '0;
    if (div_r) begin
      shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
      trial   = acc[WIDTH] ? shifted + m : shifted - m;
      acc_n   = trial;
      q_n     = {q[WIDTH-2:0], ~trial[WIDTH]};
      // Final non-restoring correction folded into the result path.
      rem     = acc_n[WIDTH] ? acc_n[WIDTH-1:0] + m[WIDTH-1:0] : acc_n[WIDTH-1:0];
      res_hi  = neg_r ? -rem : rem;
      res_lo  = neg_q ? -q_n : q_n;
    end else begin
      unique case ({q[0], q_m1})
        2'b01:   sum = acc + m;
        2'b10:   sum = acc - m;
        default: sum = acc;
      endcase
      acc_n  = {sum[WIDTH], sum[WIDTH:1]};
      q_n    = {sum[0], q[WIDTH-1:1]};
      qm1_n  = q[0];
      res_hi = acc_n[WIDTH-1:0];
      res_lo = q_n;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      div_r <= div_mode;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
      if (div_mode) begin
        q <= a[WIDTH-1] ? -a : a;
        m <= {1'b0, (b[WIDTH-1] ? -b : b)};
      end else begin
        q <= a;
        m <= {b[WIDTH-1], b};
      end
    end else if (step) begin
      acc  <= acc_n;
      q    <= q_n;
      q_m1 <= qm1_n;
      cnt  <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops resolve at the accept edge; MUL/DIV run
// WIDTH steps in muldiv_core and land in Zhigh/Zlow with a done pulse.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 6
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [CTL_W-1:0] ALU_ctl,
  output logic [WIDTH-1:0] Zhigh,
  output logic [WIDTH-1:0] Zlow,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int SH_W = clog2(WIDTH);

  state_t             state;
  logic               is_mul, is_div, b_zero, core_load, core_last;
  logic [WIDTH-1:0]   core_hi, core_lo, sc_result;
  logic [SH_W-1:0]    sh;
  logic [2*WIDTH-1:0] rot_r, rot_l;

  assign is_mul    = (ALU_ctl == CTL_W'(OP_MUL));
  assign is_div    = (ALU_ctl == CTL_W'(OP_DIV));
  assign b_zero    = (B == '0);
  assign busy      = (state != ST_IDLE);
  assign core_load = start && !busy && (is_mul || (is_div && !b_zero));

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .Clock    (Clock),
    .Clear    (Clear),
    .load     (core_load),
    .step     (busy),
    .div_mode (is_div),
    .a        (A),
    .b        (B),
    .last     (core_last),
    .res_hi   (core_hi),
    .res_lo   (core_lo)
  );

  // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
  always_comb begin
    sh        = B[SH_W-1:0];
    rot_r     = {A, A} >> sh;
    rot_l     = {A, A} << sh;
    sc_result = '0;
    case (ALU_ctl)
      CTL_W'(OP_ADD):  sc_result = A + B;
      CTL_W'(OP_SUB):  sc_result = A - B;
      CTL_W'(OP_AND):  sc_result = A & B;
      CTL_W'(OP_OR):   sc_result = A | B;
      CTL_W'(OP_SHR):  sc_result = A >> sh;
      CTL_W'(OP_SHRA): sc_result = $signed(A) >>> sh;
      CTL_W'(OP_SHL):  sc_result = A << sh;
      CTL_W'(OP_ROR):  sc_result = rot_r[WIDTH-1:0];
      CTL_W'(OP_ROL):  sc_result = rot_l[2*WIDTH-1:WIDTH];
      CTL_W'(OP_NEG):  sc_result = -A;
      CTL_W'(OP_NOT):  sc_result = ~A;
      default:         sc_result = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state       <= ST_IDLE;
      Zhigh       <= '0;
      Zlow        <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else if (is_div && !b_zero) begin
              state <= ST_DIV;
            end else if (is_div) begin
              Zlow        <= '1;
              Zhigh       <= A;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              Zlow        <= sc_result;
              Zhigh       <= '0;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) begin
            Zhigh       <= core_hi;
            Zlow        <= core_lo;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance, directed
// vectors with hand-computed results checked by a done-driven monitor.
module tb_seq_alu;

  localparam logic [5:0] C_ADD = 6'd3,  C_SUB = 6'd4,  C_AND = 6'd5,  C_OR  = 6'd6;
  localparam logic [5:0] C_SHR = 6'd7,  C_SHRA = 6'd8, C_SHL = 6'd9,  C_ROR = 6'd10;
  localparam logic [5:0] C_ROL = 6'd11, C_NEG = 6'd12, C_NOT = 6'd13, C_MUL = 6'd14;
  localparam logic [5:0] C_DIV = 6'd15;

  logic        clk = 1'b0;
  logic        clear = 1'b0;

  logic        s32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [5:0]  c32 = '0;
  logic [31:0] hi32, lo32;
  logic        busy32, done32, dbz32;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [5:0]  c8 = '0;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dbz8;

  int n_vec = 0;
  int n_err = 0;

  logic [64:0] q32[$];
  logic [64:0] q8[$];
  string       nm32[$];
  string       nm8[$];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .CTL_W(6)) dut32 (
    .Clock(clk), .Clear(clear), .start(s32), .A(a32), .B(b32), .ALU_ctl(c32),
    .Zhigh(hi32), .Zlow(lo32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  seq_alu #(.WIDTH(8), .CTL_W(6)) dut8 (
    .Clock(clk), .Clear(clear), .start(s8), .A(a8), .B(b8), .ALU_ctl(c8),
    .Zhigh(hi8), .Zlow(lo8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  function automatic logic [64:0] tup(input logic dbz, input logic [31:0] hi, input logic [31:0] lo);
    return {dbz, hi, lo};
  endfunction

  function automatic logic [64:0] tup8(input logic dbz, input logic [7:0] hi, input logic [7:0] lo);
    return {48'b0, dbz, hi, lo};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (clear && done32) begin
      if (q32.size() == 0) check("spurious_done32", 65'(done32), 65'd0);
      else check(nm32.pop_front(), tup(dbz32, hi32, lo32), q32.pop_front());
    end
    if (clear && done8) begin
      if (q8.size() == 0) check("spurious_done8", 65'(done8), 65'd0);
      else check(nm8.pop_front(), tup8(dbz8, hi8, lo8), q8.pop_front());
    end
  end

  // Issue one op, push its expectation, then time the done pulse. A nonzero
  // poke fires an ignored ADD start that many cycles into a busy op.
  task automatic issue(input bit w8, input string name, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [64:0] exp, input int lat, input int poke);
    int  cycles;
    bit  got;
    @(negedge clk);
    if (w8) begin
      s8 = 1'b1; c8 = op; a8 = a[7:0]; b8 = b[7:0];
      q8.push_back(exp); nm8.push_back(name);
    end else begin
      s32 = 1'b1; c32 = op; a32 = a; b32 = b;
      q32.push_back(exp); nm32.push_back(name);
    end
    @(posedge clk);
    #1;
    s32 = 1'b0; s8 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'h0000_0003; c32 = C_SUB;
    a8  = 8'h5A;         b8  = 8'h03;         c8  = C_SUB;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (w8 ? done8 : done32) got = 1'b1;
      if (lat > 1 && cycles == 1) check({name, "_busy"}, 65'(w8 ? busy8 : busy32), 65'd1);
      if (poke > 0 && cycles == poke) begin
        s32 = 1'b1; c32 = C_ADD; s8 = w8; c8 = C_ADD;
      end else begin
        s32 = 1'b0; s8 = 1'b0;
      end
    end
    s32 = 1'b0; s8 = 1'b0;
    check({name, "_latency"}, 65'(cycles), 65'(lat));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset32", {busy32, done32, dbz32, hi32, lo32}, '0);
    check("reset8",  65'({busy8, done8, dbz8, hi8, lo8}), '0);
    clear = 1'b1;
    repeat (2) @(negedge clk);

    issue(0, "add",  C_ADD,  32'd16, 32'd4, tup(0, 0, 32'd20),  1, 0);
    issue(0, "sub",  C_SUB,  32'd16, 32'd4, tup(0, 0, 32'd12),  1, 0);
    issue(0, "and",  C_AND,  32'd16, 32'd4, tup(0, 0, 32'd0),   1, 0);
    issue(0, "or",   C_OR,   32'd16, 32'd4, tup(0, 0, 32'd20),  1, 0);
    issue(0, "shl",  C_SHL,  32'd16, 32'd4, tup(0, 0, 32'd256), 1, 0);
    issue(0, "shr",  C_SHR,  32'd16, 32'd4, tup(0, 0, 32'd1),   1, 0);
    issue(0, "ror",  C_ROR,  32'h0000_0001, 32'd33, tup(0, 0, 32'h8000_0000), 1, 0);
    issue(0, "shra", C_SHRA, 32'h8000_0000, 32'd4,  tup(0, 0, 32'hF800_0000), 1, 0);
    issue(0, "rol",  C_ROL,  32'h8000_0001, 32'd4,  tup(0, 0, 32'h0000_0018), 1, 0);
    issue(0, "neg",  C_NEG,  32'd5, 32'd0,  tup(0, 0, 32'hFFFF_FFFB), 1, 0);
    issue(0, "not",  C_NOT,  32'd0, 32'd0,  tup(0, 0, 32'hFFFF_FFFF), 1, 0);
    issue(0, "op20", 6'd20,  32'd7, 32'd9,  tup(0, 0, 32'd0), 1, 0);

    issue(0, "mul_m3x7",   C_MUL, 32'hFFFF_FFFD, 32'd7, tup(0, 32'hFFFF_FFFF, 32'hFFFF_FFEB), 33, 5);
    issue(0, "mul_max",    C_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, tup(0, 32'h3FFF_FFFF, 32'h0000_0001), 33, 0);
    issue(0, "mul_minmin", C_MUL, 32'h8000_0000, 32'h8000_0000, tup(0, 32'h4000_0000, 32'h0), 33, 0);
    issue(0, "div_m17_5",  C_DIV, 32'hFFFF_FFEF, 32'd5, tup(0, 32'hFFFF_FFFE, 32'hFFFF_FFFD), 33, 0);
    issue(0, "div_100_7",  C_DIV, 32'd100, 32'd7, tup(0, 32'd2, 32'd14), 33, 0);
    issue(0, "div_7_m2",   C_DIV, 32'd7, 32'hFFFF_FFFE, tup(0, 32'd1, 32'hFFFF_FFFD), 33, 0);
    issue(0, "div_min_m1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, tup(0, 32'd0, 32'h8000_0000), 33, 0);
    issue(0, "div_by_0",   C_DIV, 32'd9, 32'd0, tup(1, 32'd9, 32'hFFFF_FFFF), 1, 0);
    repeat (3) @(negedge clk);
    check("dbz_held", 65'(dbz32), 65'd1);

    issue(1, "mul8_minmin", C_MUL, 32'h80, 32'h80, tup8(0, 8'h40, 8'h00), 9, 0);
    issue(1, "div8_min_m1", C_DIV, 32'h80, 32'hFF, tup8(0, 8'h00, 8'h80), 9, 0);
    issue(1, "mul8_m3x7",   C_MUL, 32'hFD, 32'h07, tup8(0, 8'hFF, 8'hEB), 9, 0);

    // Clear mid-multiply: outputs drop without waiting for a clock edge.
    @(negedge clk);
    s32 = 1'b1; c32 = C_MUL; a32 = 32'd3; b32 = 32'd5;
    @(posedge clk);
    #1 s32 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("busy_before_clear", 65'(busy32), 65'd1);
    clear = 1'b0;
    #1;
    check("clear_async", {busy32, done32, dbz32, hi32, lo32}, '0);
    @(negedge clk);
    clear = 1'b1;
    issue(0, "add_after_clear", C_ADD, 32'd16, 32'd4, tup(0, 0, 32'd20), 1, 0);
    repeat (40) @(negedge clk);
    check("scoreboard_drained", 65'(q32.size() + q8.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
